// File: rtl/bc_pkg.sv
// Shared Basic Computer definitions: memory geometry, arbiter owner state
// and the read-return tag used by mem_port_arbiter.
package bc_pkg;

  localparam int BC_AW = 12;
  localparam int BC_DW = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } owner_t;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between the CPU datapath and the DMA
// loader: CPU priority with a bounded CPU run, DMA burst lock, 1-cycle reads.
module mem_port_arbiter
  import bc_pkg::*;
#(
  parameter int AW          = BC_AW,
  parameter int DW          = BC_DW,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] MAX_RUN = 4'(MAX_CPU_RUN);

  owner_t     owner_q, owner_d;
  logic [3:0] run_cnt_q, run_cnt_d;
  rd_tag_t    tag_q, tag_d;

  // Grant decision in priority order, plus memory mux and read return.
  always_comb begin
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {AW{1'b0}};
    mem_wdata  = {DW{1'b0}};
    cpu_rvalid = 1'b0;
    dma_rvalid = 1'b0;
    rdata      = {DW{1'b0}};
    if (reset) begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end else if (owner_q == DMA && dma_lock && dma_req) begin
      dma_gnt = 1'b1;
    end else if (cpu_req && dma_req) begin
      if (run_cnt_q == MAX_RUN) dma_gnt = 1'b1;
      else                      cpu_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (dma_req) begin
      dma_gnt = 1'b1;
    end else begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end

    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else begin
      mem_we    = 1'b0;
    end

    // A reset arriving while a read is in flight swallows its return.
    if (!reset && tag_q.valid) begin
      rdata      = mem_rdata;
      cpu_rvalid = (tag_q.port == PORT_CPU);
      dma_rvalid = (tag_q.port == PORT_DMA);
    end else begin
      rdata      = {DW{1'b0}};
    end
  end

  assign mem_en    = cpu_gnt | dma_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;

  // Next owner, CPU run counter and read tag.
  always_comb begin
    owner_d   = IDLE;
    run_cnt_d = run_cnt_q;
    tag_d     = '{valid: 1'b0, port: PORT_CPU};
    if (cpu_gnt)      owner_d = CPU;
    else if (dma_gnt) owner_d = DMA;
    else              owner_d = IDLE;

    if (dma_gnt || !dma_req)                  run_cnt_d = 4'd0;
    else if (cpu_gnt && run_cnt_q != MAX_RUN) run_cnt_d = run_cnt_q + 4'd1;
    else                                      run_cnt_d = run_cnt_q;

    if (mem_en && !mem_we) tag_d = '{valid: 1'b1, port: dma_gnt ? PORT_DMA : PORT_CPU};
    else                   tag_d = '{valid: 1'b0, port: PORT_CPU};
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= IDLE;
      run_cnt_q <= 4'd0;
      tag_q     <= '{valid: 1'b0, port: PORT_CPU};
    end else begin
      owner_q   <= owner_d;
      run_cnt_q <= run_cnt_d;
      tag_q     <= tag_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// 4096 x 16 synchronous memory attached to the mem_* port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [11:0] cpu_addr, dma_addr, mem_addr;
  logic [15:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata, rdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;

  logic [15:0] mem [0:4095];
  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(12), .DW(16), .MAX_CPU_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous memory model.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 16'h0000;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 12'h000; dma_wdata = 16'h0000;
    dma_lock = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h0A5] = 16'h7001;
    mem_rdata = 16'h0000;
    idle_inputs();
    reset = 1'b1;

    // Reset held with both requesters active.
    cpu_req = 1'b1; dma_req = 1'b1;
    step(); step(); #1;
    chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);

    step(); reset = 1'b0; #1;
    chk("first_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("first_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    step(); idle_inputs(); #1;
    chk("idle_mem_en", {31'd0, mem_en}, 32'd0);

    // CPU read of 0x0A5.
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0A5; #1;
    chk("rd_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("rd_mem_addr", {20'd0, mem_addr}, 32'h0A5);
    chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rd_stall", {31'd0, cpu_stall}, 32'd0);
    step(); idle_inputs(); #1;
    chk("rd_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("rd_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    chk("rd_rdata", {16'd0, rdata}, 32'h7001);
    step(); #1;
    chk("rd_rvalid_gone", {31'd0, cpu_rvalid}, 32'd0);

    // Starvation bound: C,C,C,C,D repeated.
    for (int i = 0; i < 10; i++) begin
      step();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h300; cpu_wdata = 16'h1111;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h301; dma_wdata = 16'h2222;
      #1;
      chk($sformatf("starve_cpu_gnt_%0d", i), {31'd0, cpu_gnt}, (i % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("starve_dma_gnt_%0d", i), {31'd0, dma_gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_stall_%0d", i), {31'd0, cpu_stall}, (i % 5 == 4) ? 32'd1 : 32'd0);
    end
    step(); idle_inputs();

    // DMA lock burst writing 0x100..0x105, CPU requesting from the second cycle.
    for (int i = 0; i < 6; i++) begin
      step();
      dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1;
      dma_addr = 12'h100 + 12'(i); dma_wdata = 16'hA000 + 16'(i);
      cpu_req = (i > 0); cpu_we = 1'b0; cpu_addr = 12'h0A5;
      #1;
      chk($sformatf("lock_dma_gnt_%0d", i), {31'd0, dma_gnt}, 32'd1);
      chk($sformatf("lock_addr_%0d", i), {20'd0, mem_addr}, 32'h100 + i);
      chk($sformatf("lock_stall_%0d", i), {31'd0, cpu_stall}, (i > 0) ? 32'd1 : 32'd0);
      chk($sformatf("lock_no_dma_rvalid_%0d", i), {31'd0, dma_rvalid}, 32'd0);
    end
    step(); dma_req = 1'b0; dma_lock = 1'b0; #1;
    chk("lock_release_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("lock_release_stall", {31'd0, cpu_stall}, 32'd0);
    step(); idle_inputs(); #1;
    chk("lock_release_rdata", {16'd0, rdata}, 32'h7001);

    // DMA read of a burst location.
    step(); dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h103; #1;
    chk("dma_rd_gnt", {31'd0, dma_gnt}, 32'd1);
    step(); idle_inputs(); #1;
    chk("dma_rd_rvalid", {31'd0, dma_rvalid}, 32'd1);
    chk("dma_rd_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("dma_rd_rdata", {16'd0, rdata}, 32'hA003);

    // DMA write 0xBEEF at 0x200 then CPU read.
    step(); dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h200; dma_wdata = 16'hBEEF; #1;
    chk("wr_dma_gnt", {31'd0, dma_gnt}, 32'd1);
    chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
    chk("wr_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    step(); idle_inputs(); cpu_req = 1'b1; cpu_addr = 12'h200; #1;
    chk("wr_rd_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("wr_no_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    step(); idle_inputs(); #1;
    chk("wr_rd_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("wr_rd_rdata", {16'd0, rdata}, 32'hBEEF);

    // Reset in the cycle after a CPU read grant.
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0A5; #1;
    chk("midrst_gnt", {31'd0, cpu_gnt}, 32'd1);
    step(); idle_inputs(); reset = 1'b1; #1;
    chk("midrst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("midrst_rdata", {16'd0, rdata}, 32'd0);
    step(); reset = 1'b0; #1;
    chk("midrst_after", {31'd0, cpu_rvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
